// File: rtl/lab1_imul_prod_accum.sv
// Product accumulator: sums fixed-length frames of multiplier products
// (mod 2^32) and presents each completed sum on a val/rdy output stream.
module lab1_imul_prod_accum #(
    parameter int unsigned p_max_terms = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_cfg_nterms,
    input  logic        i_istream_val,
    output logic        o_istream_rdy,
    input  logic [31:0] i_istream_msg,
    output logic        o_ostream_val,
    input  logic        i_ostream_rdy,
    output logic [31:0] o_ostream_msg
);

    localparam int          CW        = $clog2(p_max_terms + 1);
    localparam logic [31:0] MAX_TERMS = 32'(p_max_terms);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_len;
    logic [31:0]   r_sum;

    logic [31:0]   w_cfg_ext;
    logic [CW-1:0] w_len_new;
    logic [CW-1:0] w_cnt_inc;
    logic          w_in_fire;
    logic          w_out_fire;

    // Clamp the requested frame length into 1..p_max_terms for latching on a first term
    always_comb begin
        w_cfg_ext = {24'd0, i_cfg_nterms};
        w_len_new = CW'(1);
        if (w_cfg_ext == 32'd0)
            w_len_new = CW'(1);
        else if (w_cfg_ext > MAX_TERMS)
            w_len_new = MAX_TERMS[CW-1:0];
        else
            w_len_new = w_cfg_ext[CW-1:0];
    end

    // Handshake signals; input readiness follows the sink while a sum is pending so a
    // new frame can start in the same cycle the old sum drains
    always_comb begin
        o_istream_rdy = reset | (r_state == ACC) | i_ostream_rdy;
        o_ostream_val = ~reset & (r_state == OUT);
        o_ostream_msg = r_sum;
        w_in_fire     = i_istream_val & o_istream_rdy;
        w_out_fire    = o_ostream_val & i_ostream_rdy;
        w_cnt_inc     = r_cnt + CW'(1);
    end

    // Frame FSM: accumulate terms in ACC, hold the finished sum in OUT until it drains
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACC;
            r_cnt   <= '0;
            r_len   <= CW'(1);
            r_sum   <= 32'd0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_in_fire) begin
                        if (r_cnt == '0) begin
                            r_sum <= i_istream_msg;
                            r_len <= w_len_new;
                            if (w_len_new == CW'(1)) begin
                                r_state <= OUT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= CW'(1);
                            end
                        end else begin
                            r_sum <= r_sum + i_istream_msg;
                            if (w_cnt_inc == r_len) begin
                                r_state <= OUT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                end
                OUT: begin
                    if (w_out_fire) begin
                        if (w_in_fire) begin
                            r_sum <= i_istream_msg;
                            r_len <= w_len_new;
                            if (w_len_new == CW'(1)) begin
                                r_state <= OUT;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= ACC;
                                r_cnt   <= CW'(1);
                            end
                        end else begin
                            r_state <= ACC;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ACC;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
